// File: rtl/seq_det_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_param
// Description : Serial pattern detector with a run-time loadable PAT_LEN-bit
//               pattern, input qualifier, overlap mode and saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] DEF_PAT = 4'b1001,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               overlap_en,
  input  logic               in_valid,
  input  logic               inp_1,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               armed
);

  localparam int               c_FILL_W = $clog2(PAT_LEN + 1);
  localparam [c_FILL_W-1:0]    c_FULL   = c_FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0]  r_pat;
  logic [PAT_LEN-1:0]  r_hist;
  logic [c_FILL_W-1:0] r_fill;
  logic                r_match;
  logic [CNT_W-1:0]    r_cnt;

  logic [PAT_LEN-1:0]  w_nh;
  logic [c_FILL_W-1:0] w_nf;
  logic                w_hit;

  always_comb begin
    w_nh  = {r_hist[PAT_LEN-2:0], inp_1};
    w_nf  = (r_fill == c_FULL) ? c_FULL : r_fill + 1'b1;
    w_hit = (w_nf == c_FULL) && (w_nh == r_pat);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pat   <= DEF_PAT;
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
      r_cnt   <= '0;
    end else if (load) begin
      r_pat   <= pat_in;
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
      r_cnt   <= '0;
    end else if (in_valid) begin
      r_hist  <= w_nh;
      r_match <= w_hit;
      if (w_hit) begin
        if (!(&r_cnt)) r_cnt <= r_cnt + 1'b1;
        // Non-overlap keeps the history but demands PAT_LEN fresh bits.
        r_fill <= overlap_en ? w_nf : '0;
      end else begin
        r_fill <= w_nf;
      end
    end else begin
      r_match <= 1'b0;
    end
  end

  assign match     = r_match;
  assign match_cnt = r_cnt;
  assign armed     = (r_fill == c_FULL);

endmodule
`default_nettype wire

// File: tb/tb_seq_det_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_det_param
// Description : Directed self-checking bench for seq_det_param.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_param;

  logic       clk = 1'b0;
  logic       reset, load, overlap_en, in_valid, inp_1;
  logic [3:0] pat_in;
  logic       match_a, armed_a, match_b, armed_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_det_param #(.PAT_LEN(4), .DEF_PAT(4'b1001), .CNT_W(8)) u_dut_a (
    .clk(clk), .reset(reset), .load(load), .pat_in(pat_in),
    .overlap_en(overlap_en), .in_valid(in_valid), .inp_1(inp_1),
    .match(match_a), .match_cnt(cnt_a), .armed(armed_a)
  );

  seq_det_param #(.PAT_LEN(4), .DEF_PAT(4'b1001), .CNT_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .load(load), .pat_in(pat_in),
    .overlap_en(overlap_en), .in_valid(in_valid), .inp_1(inp_1),
    .match(match_b), .match_cnt(cnt_b), .armed(armed_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    in_valid = 1'b1;
    inp_1    = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] p);
    load   = 1'b1;
    pat_in = p;
    tick();
    load   = 1'b0;
  endtask

  initial begin
    logic [6:0]  s7;
    logic [6:0]  m7;
    logic [6:0]  a7;
    logic [15:0] s16;
    logic [15:0] m16;
    int          pulses;

    reset = 1'b0; load = 1'b0; overlap_en = 1'b1;
    in_valid = 1'b0; inp_1 = 1'b0; pat_in = 4'h0;
    tick(); tick();
    chk("rst_match", match_a, 0);
    chk("rst_cnt",   cnt_a,   0);
    chk("rst_armed", armed_a, 0);
    reset = 1'b1;

    // T1: overlapping, bits sent MSB first
    s7 = 7'b1001001; m7 = 7'b0001001; a7 = 7'b0001111;
    for (int i = 6; i >= 0; i--) begin
      send(s7[i]);
      chk($sformatf("t1_match_%0d", 7 - i), match_a, m7[i]);
      chk($sformatf("t1_armed_%0d", 7 - i), armed_a, a7[i]);
    end
    tick();
    chk("t1_match_idle", match_a, 0);
    chk("t1_cnt", cnt_a, 2);

    // T2: non-overlapping
    do_load(4'b1001);
    chk("t2_load_cnt", cnt_a, 0);
    chk("t2_load_armed", armed_a, 0);
    overlap_en = 1'b0;
    m7 = 7'b0001000;
    for (int i = 6; i >= 0; i--) begin
      send(s7[i]);
      chk($sformatf("t2_match_%0d", 7 - i), match_a, m7[i]);
      chk($sformatf("t2_armed_%0d", 7 - i), armed_a, 0);
    end
    chk("t2_cnt", cnt_a, 1);

    // T3: gaps between valid bits
    overlap_en = 1'b1;
    do_load(4'b1001);
    s7 = 7'b0001001;
    for (int i = 3; i >= 0; i--) begin
      send(s7[i]);
      chk($sformatf("t3_match_bit%0d", 4 - i), match_a, (i == 0) ? 1 : 0);
      if (i != 0) begin
        for (int g = 0; g < 3; g++) begin
          tick();
          chk($sformatf("t3_gap_%0d_%0d", 4 - i, g), match_a, 0);
        end
      end
    end
    tick();
    chk("t3_after", match_a, 0);
    chk("t3_cnt", cnt_a, 1);

    // T4: load coincident with a valid bit drops that bit
    do_load(4'b1001);
    send(1'b1); send(1'b1);
    load = 1'b1; pat_in = 4'b1101; in_valid = 1'b1; inp_1 = 1'b1;
    tick();
    load = 1'b0; in_valid = 1'b0;
    chk("t4_cnt0", cnt_a, 0);
    chk("t4_armed0", armed_a, 0);
    s7 = 7'b0001101;
    for (int i = 3; i >= 0; i--) begin
      send(s7[i]);
      chk($sformatf("t4_match_%0d", 4 - i), match_a, (i == 0) ? 1 : 0);
    end
    chk("t4_cnt", cnt_a, 1);

    // T5: reset mid-pattern restores default pattern and discards history
    send(1'b1); send(1'b0); send(1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t5_cnt", cnt_a, 0);
    chk("t5_armed", armed_a, 0);
    send(1'b1);
    chk("t5_nomatch", match_a, 0);
    send(1'b0); send(1'b0); send(1'b1);
    chk("t5_defpat_match", match_a, 1);
    chk("t5_defpat_cnt", cnt_a, 1);

    // T6: saturation of the 2-bit counter
    do_load(4'b1001);
    overlap_en = 1'b1;
    s16 = 16'b1001001001001001;
    m16 = 16'b0001001001001001;
    pulses = 0;
    for (int i = 15; i >= 0; i--) begin
      send(s16[i]);
      if (match_b) pulses++;
      chk($sformatf("t6_match_%0d", 16 - i), match_b, m16[i]);
    end
    chk("t6_pulses", pulses, 5);
    chk("t6_cnt_sat", cnt_b, 3);
    chk("t6_cnt_wide", cnt_a, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
